wb_fetch_ctrl: RTL and testbench

Weight-fetch sequencer that sits directly downstream of the weight buffer (`Wb_Buffer`). On a start command it issues a burst of consecutive read requests to the buffer's internal read port and captures the 256-bit words that come back. It streams those words to the PE array over a valid/ready interface. Credit-based issue guarantees the local FIFO never overflows under PE backpressure.

---
 rtl/npu_wb_pkg.sv | 16 +
 rtl/wb_fetch_fifo.sv | 49 ++++
 rtl/wb_fetch_ctrl.sv | 179 +++++++++++++++++
 tb/tb_wb_fetch_ctrl.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/npu_wb_pkg.sv
// Shared weight-buffer constants and the fetch sequencer state encoding.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package npu_wb_pkg;

    localparam int WB_ADDR_W = 12;
    localparam int WB_DATA_W = 256;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/wb_fetch_fifo.sv
// Synchronous first-word-fall-through FIFO holding returned weight words.
// Latency: a word written at an edge is visible at rd_dat in the following cycle.
// Backpressure: writes while full and reads while empty are dropped; simultaneous read and write keep count.
module wb_fetch_fifo #(
    parameter int DATA_W     = 256,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            wr_vld,
    input  logic [DATA_W-1:0]               wr_dat,
    input  logic                            rd_rdy,
    output logic [DATA_W-1:0]               rd_dat,
    output logic                            empty,
    output logic                            full,
    output logic [$clog2(FIFO_DEPTH):0]     count
);
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              do_wr;
    logic              do_rd;

    assign empty  = (count == '0);
    assign full   = (count == (AW+1)'(FIFO_DEPTH));
    assign do_wr  = wr_vld & ~full;
    assign do_rd  = rd_rdy & ~empty;
    assign rd_dat = mem[rd_ptr];

    // Storage is left unreset; empty gates every consumer of rd_dat.
    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= wr_dat;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + AW'(1);
            if (do_rd) rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(do_wr) - (AW+1)'(do_rd);
        end
    end

endmodule

// File: rtl/wb_fetch_ctrl.sv
// Weight-fetch sequencer: bursts reads to the weight buffer and streams words to the PE array (WB_FETCH_REPEAT_EN adds pass replay).
// Latency: start at edge 0 -> rd_en cycle 1, buffer data cycle 2, o_w_vld cycle 3, o_done one cycle after the last pop.
// Backpressure: reads issue only while returning-plus-stored words fit the FIFO, so i_w_rdy low never loses data.
module wb_fetch_ctrl
    import npu_wb_pkg::*;
#(
    parameter int ADDR_W     = WB_ADDR_W,
    parameter int DATA_W     = WB_DATA_W,
    parameter int LEN_W      = 12,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    input  logic [ADDR_W-1:0] i_base_addr,
    input  logic [LEN_W-1:0]  i_len,
`ifdef WB_FETCH_REPEAT_EN
    input  logic [7:0]        i_repeat,
`endif
    output logic              o_busy,
    output logic              o_done,
    output logic [ADDR_W-1:0] o_wb_raddr,
    output logic              o_wb_rd_en,
    input  logic [DATA_W-1:0] i_wb_rdata,
    input  logic              i_wb_rdata_vld,
    output logic [DATA_W-1:0] o_w_data,
    output logic              o_w_vld,
    input  logic              i_w_rdy
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
`ifdef WB_FETCH_REPEAT_EN
    localparam int POP_W = LEN_W + 8;
`else
    localparam int POP_W = LEN_W;
`endif

    fetch_state_t      state;
    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W-1:0] addr_cnt;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  issue_cnt;
    logic [POP_W-1:0]  pop_cnt;
    logic [POP_W-1:0]  total_words;
    logic              inflight;
    logic              fifo_empty;
    logic              fifo_full;
    logic [CNT_W-1:0]  fifo_count;
    logic [DATA_W-1:0] fifo_head;
    logic              push;
    logic              pop;
    logic [CNT_W-1:0]  count_next;
    logic [CNT_W:0]    pending;
    logic              credit_ok;
    logic              issue;
    logic              reload;
    logic              start_reload;

    assign push      = i_wb_rdata_vld & inflight & ~fifo_full;
    assign pop       = o_w_vld & i_w_rdy;
    assign o_w_vld   = ~fifo_empty;
    assign o_w_data  = fifo_empty ? '0 : fifo_head;

    // Decide next cycle's read: words stored after this edge plus the read now on the bus must leave a free slot.
    assign count_next = fifo_count + CNT_W'(push) - CNT_W'(pop);
    assign pending    = {1'b0, count_next} + (CNT_W+1)'(o_wb_rd_en);
    assign credit_ok  = pending < (CNT_W+1)'(FIFO_DEPTH);
    assign issue      = (state == ISSUE) && (issue_cnt != '0) && credit_ok;

`ifdef WB_FETCH_REPEAT_EN
    logic [7:0] pass_cnt;

    assign reload       = (issue_cnt == LEN_W'(1)) && (pass_cnt != 8'd0);
    assign start_reload = (i_len == LEN_W'(1)) && (i_repeat != 8'd0);
    assign total_words  = POP_W'(i_len) * POP_W'(i_repeat) + POP_W'(i_len);

    always_ff @(posedge clk) begin
        if (!rst) begin
            pass_cnt <= 8'd0;
        end else if (state == IDLE && i_start) begin
            pass_cnt <= start_reload ? i_repeat - 8'd1 : i_repeat;
        end else if (issue && reload) begin
            pass_cnt <= pass_cnt - 8'd1;
        end
    end
`else
    assign reload       = 1'b0;
    assign start_reload = 1'b0;
    assign total_words  = i_len;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
            o_wb_rd_en <= 1'b0;
            o_wb_raddr <= '0;
            inflight   <= 1'b0;
            base_q     <= '0;
            addr_cnt   <= '0;
            len_q      <= '0;
            issue_cnt  <= '0;
            pop_cnt    <= '0;
        end else begin
            inflight   <= o_wb_rd_en;
            o_done     <= 1'b0;
            o_wb_rd_en <= 1'b0;
            if (pop) pop_cnt <= pop_cnt - POP_W'(1);
            case (state)
                IDLE: begin
                    if (i_start) begin
                        base_q  <= i_base_addr;
                        len_q   <= i_len;
                        pop_cnt <= total_words;
                        o_busy  <= 1'b1;
                        if (i_len == '0) begin
                            state  <= DONE;
                            o_done <= 1'b1;
                        end else begin
                            // First read goes out straight from the command to hit cycle 1.
                            state      <= ISSUE;
                            o_wb_rd_en <= 1'b1;
                            o_wb_raddr <= i_base_addr;
                            if (start_reload) begin
                                addr_cnt  <= i_base_addr;
                                issue_cnt <= i_len;
                            end else begin
                                addr_cnt  <= i_base_addr + ADDR_W'(1);
                                issue_cnt <= i_len - LEN_W'(1);
                            end
                        end
                    end
                end
                ISSUE: begin
                    if (issue) begin
                        o_wb_rd_en <= 1'b1;
                        o_wb_raddr <= addr_cnt;
                        if (reload) begin
                            addr_cnt  <= base_q;
                            issue_cnt <= len_q;
                        end else begin
                            addr_cnt  <= addr_cnt + ADDR_W'(1);
                            issue_cnt <= issue_cnt - LEN_W'(1);
                        end
                    end else if (issue_cnt == '0) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (pop && pop_cnt == POP_W'(1)) begin
                        state  <= DONE;
                        o_done <= 1'b1;
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    o_busy <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    wb_fetch_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .wr_vld (push),
        .wr_dat (i_wb_rdata),
        .rd_rdy (pop),
        .rd_dat (fifo_head),
        .empty  (fifo_empty),
        .full   (fifo_full),
        .count  (fifo_count)
    );

endmodule

// File: tb/tb_wb_fetch_ctrl.sv
// Bench for wb_fetch_ctrl: buffer responder, address/data scoreboard and cycle-relative event capture.
module tb_wb_fetch_ctrl;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         i_start = 1'b0;
    logic [11:0]  i_base_addr = '0;
    logic [11:0]  i_len = '0;
    logic [7:0]   i_repeat = '0;
    logic         o_busy, o_done, o_wb_rd_en, o_w_vld;
    logic [11:0]  o_wb_raddr;
    logic [255:0] i_wb_rdata, o_w_data;
    logic         i_wb_rdata_vld;
    logic         i_w_rdy = 1'b1;

    logic         buf_vld = 1'b0;
    logic [255:0] buf_dat = '0;
    logic         stray_vld = 1'b0;
    logic [7:0]   salt = 8'h00;

    int tests = 0, fails = 0;
    int pcyc = 0, start_p = 0;
    int rd_count = 0, pop_count = 0, done_count = 0;
    int first_rd_rel = -1, first_vld_rel = -1, done_rel = -1;
    bit rand_rdy = 0;
    logic [11:0]  addr_q[$];
    logic [255:0] exp_q[$];

    always #5 clk = ~clk;

    wb_fetch_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .i_start        (i_start),
        .i_base_addr    (i_base_addr),
        .i_len          (i_len),
`ifdef WB_FETCH_REPEAT_EN
        .i_repeat       (i_repeat),
`endif
        .o_busy         (o_busy),
        .o_done         (o_done),
        .o_wb_raddr     (o_wb_raddr),
        .o_wb_rd_en     (o_wb_rd_en),
        .i_wb_rdata     (i_wb_rdata),
        .i_wb_rdata_vld (i_wb_rdata_vld),
        .o_w_data       (o_w_data),
        .o_w_vld        (o_w_vld),
        .i_w_rdy        (i_w_rdy)
    );

    function automatic logic [255:0] wdata(input logic [11:0] a, input logic [7:0] s);
        logic [255:0] r;
        logic [31:0]  w;
        w = {s, 12'h000, a} ^ (32'(a) * 32'h9E3779B1);
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = w ^ (32'(i) * 32'h01010101);
        return r;
    endfunction

    // One-cycle-latency weight buffer.
    always @(posedge clk) begin
        buf_vld <= o_wb_rd_en;
        buf_dat <= wdata(o_wb_raddr, salt);
        pcyc    <= pcyc + 1;
    end
    assign i_wb_rdata     = buf_dat;
    assign i_wb_rdata_vld = buf_vld | stray_vld;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            if (o_wb_rd_en) begin
                rd_count++;
                if (first_rd_rel < 0) first_rd_rel = pcyc - start_p;
                if (addr_q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL raddr_extra: got read of %0h expected none", o_wb_raddr);
                end else chk("raddr", 256'(o_wb_raddr), 256'(addr_q.pop_front()));
            end
            if (o_w_vld && first_vld_rel < 0) first_vld_rel = pcyc - start_p;
            if (o_w_vld && i_w_rdy) begin
                pop_count++;
                if (exp_q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL wdata_extra: got word %0h expected none", o_w_data);
                end else chk("wdata", o_w_data, exp_q.pop_front());
            end
            if (o_done) begin
                done_count++;
                done_rel = pcyc - start_p;
            end
        end
    end

    task automatic step();
        @(posedge clk); #1;
        if (rand_rdy) i_w_rdy = 1'($urandom_range(0, 1));
    endtask

    task automatic cmd(input logic [11:0] base, input logic [11:0] len, input logic [7:0] rep);
        int passes;
        passes = 1;
`ifdef WB_FETCH_REPEAT_EN
        passes = int'(rep) + 1;
`endif
        salt = salt + 8'd1;
        for (int p = 0; p < passes; p++)
            for (int i = 0; i < int'(len); i++) begin
                addr_q.push_back(base + 12'(i));
                exp_q.push_back(wdata(base + 12'(i), salt));
            end
        @(posedge clk); #1;
        i_start = 1'b1; i_base_addr = base; i_len = len; i_repeat = rep;
        start_p = pcyc; first_rd_rel = -1; first_vld_rel = -1; done_rel = -1;
        step();
        i_start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int dc, n;
        dc = done_count; n = 0;
        while (done_count == dc && n < budget) begin
            step();
            n++;
        end
        tests++;
        if (done_count == dc) begin
            fails++;
            $display("FAIL done_timeout: got no o_done in %0d cycles expected one", budget);
        end
        i_w_rdy = 1'b1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_busy"},  256'(o_busy), 256'(0));
        chk({tag, "_done"},  256'(o_done), 256'(0));
        chk({tag, "_rd_en"}, 256'(o_wb_rd_en), 256'(0));
        chk({tag, "_raddr"}, 256'(o_wb_raddr), 256'(0));
        chk({tag, "_w_vld"}, 256'(o_w_vld), 256'(0));
        chk({tag, "_w_data"}, o_w_data, 256'(0));
    endtask

    initial begin
        int rd0, pop0, dn0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        rst = 1'b1;

        // Basic latency/throughput.
        rd0 = rd_count; pop0 = pop_count;
        cmd(12'h010, 12'd5, 8'd0);
        wait_done(100);
        chk("t1_first_rd_cycle", 256'(first_rd_rel), 256'(1));
        chk("t1_first_vld_cycle", 256'(first_vld_rel), 256'(3));
        chk("t1_done_cycle", 256'(done_rel), 256'(8));
        chk("t1_reads", 256'(rd_count - rd0), 256'(5));
        chk("t1_pops", 256'(pop_count - pop0), 256'(5));
        chk("t1_busy_after", 256'(o_busy), 256'(0));

        // Address wrap.
        cmd(12'hFFE, 12'd4, 8'd0);
        wait_done(100);
        chk("wrap_addr_q_empty", 256'(addr_q.size()), 256'(0));
        chk("wrap_done_cycle", 256'(done_rel), 256'(7));

        // Backpressure: credits cap reads at FIFO depth.
        i_w_rdy = 1'b0;
        rd0 = rd_count; pop0 = pop_count;
        cmd(12'h200, 12'd10, 8'd0);
        repeat (10) step();
        for (int i = 0; i < 10; i++) begin
            step();
            chk("bp_vld_held", 256'(o_w_vld), 256'(1));
            chk("bp_head_stable", o_w_data, exp_q[0]);
        end
        chk("bp_reads_capped", 256'(rd_count - rd0), 256'(4));
        i_w_rdy = 1'b1;
        start_p = pcyc; first_rd_rel = -1;
        wait_done(100);
        chk("bp_resume_cycle", 256'(first_rd_rel), 256'(1));
        chk("bp_reads_total", 256'(rd_count - rd0), 256'(10));
        chk("bp_pops_total", 256'(pop_count - pop0), 256'(10));
        chk("bp_exp_empty", 256'(exp_q.size()), 256'(0));

        // Zero-length command.
        rd0 = rd_count;
        cmd(12'h055, 12'd0, 8'd0);
        wait_done(20);
        chk("len0_done_cycle", 256'(done_rel), 256'(1));
        chk("len0_no_reads", 256'(rd_count - rd0), 256'(0));

        // Start while busy is ignored.
        rd0 = rd_count; pop0 = pop_count; dn0 = done_count;
        cmd(12'h100, 12'd8, 8'd0);
        step();
        i_start = 1'b1; i_base_addr = 12'h300; i_len = 12'd2;
        step();
        i_start = 1'b0;
        wait_done(100);
        repeat (4) step();
        chk("busy_start_reads", 256'(rd_count - rd0), 256'(8));
        chk("busy_start_pops", 256'(pop_count - pop0), 256'(8));
        chk("busy_start_dones", 256'(done_count - dn0), 256'(1));

        // Reset mid-command.
        dn0 = done_count;
        cmd(12'h400, 12'd8, 8'd0);
        repeat (3) step();
        rst = 1'b0;
        step();
        rst = 1'b1;
        addr_q.delete(); exp_q.delete();
        chk_reset_outputs("midrst");
        stray_vld = 1'b1;
        repeat (2) step();
        stray_vld = 1'b0;
        step();
        chk("midrst_stray_dropped", 256'(o_w_vld), 256'(0));
        chk("midrst_no_done", 256'(done_count - dn0), 256'(0));
        pop0 = pop_count;
        cmd(12'h7F0, 12'd3, 8'd0);
        wait_done(100);
        chk("midrst_recover_pops", 256'(pop_count - pop0), 256'(3));
        chk("midrst_recover_done_cycle", 256'(done_rel), 256'(6));

        // Randomized commands under random backpressure.
        rand_rdy = 1;
        for (int k = 0; k < 8; k++) begin
            cmd(12'($urandom), 12'($urandom_range(1, 12)), 8'd0);
            wait_done(400);
            chk("rand_exp_empty", 256'(exp_q.size()), 256'(0));
        end
        rand_rdy = 0;
        i_w_rdy = 1'b1;

`ifdef WB_FETCH_REPEAT_EN
        rd0 = rd_count; pop0 = pop_count; dn0 = done_count;
        cmd(12'h020, 12'd3, 8'd2);
        wait_done(100);
        repeat (3) step();
        chk("rep_reads", 256'(rd_count - rd0), 256'(9));
        chk("rep_pops", 256'(pop_count - pop0), 256'(9));
        chk("rep_dones", 256'(done_count - dn0), 256'(1));
        chk("rep_done_cycle", 256'(done_rel), 256'(12));
        cmd(12'hFFF, 12'd1, 8'd3);
        wait_done(100);
        chk("rep_len1_done_cycle", 256'(done_rel), 256'(7));
        i_repeat = 8'd0;
`endif

        repeat (3) step();
        chk("final_addr_q_empty", 256'(addr_q.size()), 256'(0));
        chk("final_exp_q_empty", 256'(exp_q.size()), 256'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish expected finish before 500000");
        $fatal(1, "timeout");
    end

endmodule
